// File: rtl/word_gather_pkg.sv
// Shared stream basics: the FILL/FULL state type and sizing helpers
// used by word_gather and its interface.
package word_gather_pkg;

  typedef logic [0:0] state_t;

  localparam state_t FILL = 1'b0;
  localparam state_t FULL = 1'b1;

  function automatic int count_bits(input int words);
    return $clog2(words + 1);
  endfunction

endpackage

// File: rtl/word_gather_if.sv
// Producer/consumer bundle for word_gather. The slave side belongs to the
// gatherer; the master side drives words in and takes vectors out.
interface word_gather_if
  import word_gather_pkg::*;
#(
  parameter int BITS  = 64,
  parameter int WORDS = 2
);

  logic                            in_valid;
  logic                            in_ready;
  logic [BITS-1:0]                 in_data;
  logic                            in_last;
  logic                            out_valid;
  logic                            out_ready;
  logic [BITS-1:0]                 out_data [WORDS];
  logic [count_bits(WORDS)-1:0]    out_count;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count
  );

endinterface

// File: rtl/word_gather.sv
// Collects BITS-wide words into a WORDS-slot vector, closing early on in_last,
// and holds the vector until the consumer takes it.
module word_gather
  import word_gather_pkg::*;
#(
  parameter int BITS  = 64,
  parameter int WORDS = 2
) (
  input logic          clk,
  input logic          reset,
  word_gather_if.slave bus
);

  localparam int IW = $clog2(WORDS);
  localparam int CW = count_bits(WORDS);
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  state_t          state;
  logic [IW-1:0]   idx;
  logic [CW-1:0]   count;
  logic [BITS-1:0] slots [WORDS];

  // Handshake flags decode state only, so no input reaches them combinationally.
  assign bus.in_ready  = (state == FILL);
  assign bus.out_valid = (state == FULL);
  assign bus.out_data  = slots;
  assign bus.out_count = count;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FILL;
      idx   <= '0;
      count <= '0;
      for (int k = 0; k < WORDS; k++) slots[k] <= '0;
    end else if (state == FILL) begin
      if (bus.in_valid) begin
        for (int k = 0; k < WORDS; k++) begin
          if (idx == IW'(k)) slots[k] <= bus.in_data;
        end
        if (bus.in_last || idx == LAST_IDX) begin
          state <= FULL;
          count <= CW'(idx) + CW'(1);
          idx   <= '0;
        end else begin
          idx <= idx + IW'(1);
        end
      end
    end else if (bus.out_ready) begin
      // Clearing on release lets a later early-closed vector show zeros.
      state <= FILL;
      for (int k = 0; k < WORDS; k++) slots[k] <= '0;
    end
  end

endmodule

// File: doc/word_gather.md
WORD_GATHER -- requirements
Module: word_gather

Interface
REQ-001 Parameter BITS, default 64: width of one data word.
REQ-002 Parameter WORDS, default 2: words per assembled vector; SHALL be >= 2.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  producer presents in_data.
REQ-006 in_ready  output  1  block accepts a word this cycle.
REQ-007 in_data  input  BITS  word to place in the next free slot.
REQ-008 in_last  input  1  qualified by in_valid; the accepted word closes the vector early.
REQ-009 out_valid  output  1  assembled vector available.
REQ-010 out_ready  input  1  consumer takes the vector this cycle.
REQ-011 out_data  output  BITS x WORDS, unpacked array indexed 0..WORDS-1  assembled vector; slot k holds the k-th accepted word.
REQ-012 out_count  output  $clog2(WORDS+1)  number of valid slots, 1..WORDS, meaningful while out_valid.

Function
REQ-013 State machine SHALL have two states: FILL (collecting) and FULL (holding a vector).
REQ-014 in_ready SHALL be 1 exactly in FILL; out_valid SHALL be 1 exactly in FULL; both are registered-state decodes with no combinational path from in_valid or out_ready.
REQ-015 Input handshake = in_valid & in_ready; on it, in_data SHALL be written to slot idx, where idx is a $clog2(WORDS)-bit write index.
REQ-016 On an input handshake with idx < WORDS-1 and in_last=0, idx SHALL increment and the state SHALL stay FILL.
REQ-017 On an input handshake with idx == WORDS-1, or with in_last=1, the block SHALL go to FULL, set out_count = idx+1, and reset idx to 0.
REQ-018 In FULL, out_data and out_count SHALL remain stable until the output handshake (out_valid & out_ready).
REQ-019 On the output handshake the block SHALL return to FILL and clear every slot to zero, so that unfilled slots of a later early-closed vector read zero.
REQ-020 The first word SHALL be accepted no earlier than the cycle after the output handshake; there is no same-cycle bypass, and sustained throughput is one vector per WORDS+1 cycles.
REQ-021 in_data, in_last and in_valid SHALL be ignored while in FULL; a producer holding in_valid high SHALL lose no data.
REQ-022 out_ready while in FILL SHALL have no effect.
REQ-023 in_last on the WORDS-th word SHALL be equivalent to no in_last (out_count = WORDS).

Reset
REQ-024 reset SHALL take priority over every handshake in the same cycle.
REQ-025 After reset: state FILL, idx 0, all slots 0, out_count 0, in_ready 1, out_valid 0.
REQ-026 Reset asserted mid-fill or in FULL SHALL discard the partial or held vector with no output handshake.

Structure
REQ-027 The FILL/FULL state typedef SHALL reside in the shared basics package for reuse by other stream blocks.
REQ-028 The block SHALL be a single module with no sub-module; slot write-enable decode SHALL be inline (the inverse of the shared Mux selection).

Verification
REQ-029 WORDS=2: send 64'hA then 64'hB with no in_last, out_ready=0 -> out_valid rises the cycle after the 2nd accept, out_data={A,B}, out_count=2, in_ready=0; holds for 5 idle cycles.
REQ-030 WORDS=4: send 64'h1 with in_last=1 -> out_data={1,0,0,0}, out_count=1; a following full vector 5,6,7,8 -> {5,6,7,8}, count 4.
REQ-031 Back-to-back, in_valid held high with out_ready=1 -> 3 vectors delivered in 9 cycles (WORDS=2), order preserved, no word dropped or duplicated.
REQ-032 Assert reset after 1 accepted word of a WORDS=2 vector, then send C,D -> out_data={C,D}; the earlier word never appears.
REQ-033 Assert reset in the same cycle as the output handshake, and separately as an input handshake -> reset state of REQ-025 next cycle, in_ready=1.
REQ-034 in_last on the final (WORDS-th) word -> out_count=WORDS, identical to the no-in_last case.
